// File: rtl/sample_filter_stage.sv
// Per-sample DSP stage: delayed relay, differentiator or 2^LOG2_TAPS moving average.
// Define SAMPLE_FILTER_SAT_EN to clamp the differentiator instead of wrapping it.
module sample_filter_stage #(
    parameter int LOG2_TAPS = 3,
    parameter int DW        = 14
) (
    input  logic                 CLK_50M,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic signed [DW-1:0] sample_in,
    input  logic [1:0]           mode,
    output logic signed [DW-1:0] y_out,
    output logic [11:0]          dac_code,
    output logic                 out_valid,
    output logic                 overflow
);
    localparam int TAPS = 1 << LOG2_TAPS;
    localparam int SW   = DW + LOG2_TAPS;

    localparam logic signed [DW-1:0] MAX_VAL = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] MIN_VAL = {1'b1, {(DW-1){1'b0}}};

    logic                 tick_q;
    logic                 accept;
    logic                 stage1_valid;
    logic signed [DW-1:0] hist [TAPS];
    logic signed [DW-1:0] x_prev;
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] sum_next;
    logic [1:0]           mode_q;
    logic [DW:0]          diff;
    logic                 diff_oor;
    logic signed [DW-1:0] diff_res;
    logic signed [DW-1:0] y_next;

    // out_valid is a strobe, not a handshake: it is high for exactly one
    // clock per accepted sample and there is no ready/back-pressure path.
    assign accept = sample_tick & ~tick_q;

    assign sum_next = sum
                    + {{LOG2_TAPS{sample_in[DW-1]}}, sample_in}
                    - {{LOG2_TAPS{hist[TAPS-1][DW-1]}}, hist[TAPS-1]};

    always_ff @(posedge CLK_50M or posedge reset) begin
        if (reset) begin
            tick_q       <= 1'b0;
            stage1_valid <= 1'b0;
            x_prev       <= '0;
            sum          <= '0;
            mode_q       <= 2'b00;
            for (int k = 0; k < TAPS; k++) begin
                hist[k] <= '0;
            end
        end else begin
            tick_q       <= sample_tick;
            stage1_valid <= accept;
            if (accept) begin
                hist[0] <= sample_in;
                for (int k = 1; k < TAPS; k++) begin
                    hist[k] <= hist[k-1];
                end
                x_prev <= hist[0];
                sum    <= sum_next;
                mode_q <= mode;
            end
        end
    end

    // Differentiator is computed one bit wider so the true result is always visible.
    assign diff     = {hist[0][DW-1], hist[0]} - {x_prev[DW-1], x_prev};
    assign diff_oor = diff[DW] ^ diff[DW-1];

`ifdef SAMPLE_FILTER_SAT_EN
    assign diff_res = diff_oor ? (diff[DW] ? MIN_VAL : MAX_VAL) : diff[DW-1:0];
`else
    assign diff_res = diff[DW-1:0];
`endif

    always_comb begin
        y_next = '0;
        case (mode_q)
            2'b00:   y_next = x_prev;
            2'b01:   y_next = diff_res;
            2'b10:   y_next = sum[SW-1:LOG2_TAPS];
            default: y_next = '0;
        endcase
    end

    always_ff @(posedge CLK_50M or posedge reset) begin
        if (reset) begin
            y_out     <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= stage1_valid;
            if (stage1_valid) begin
                y_out <= y_next;
                if (mode_q == 2'b01 && diff_oor) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    // Offset-binary view of the registered result; reset value 0 maps to 12'h800.
    assign dac_code = {~y_out[DW-1], y_out[DW-2:DW-12]};

endmodule

// File: tb/tb_sample_filter_stage.sv
// Self-checking bench for sample_filter_stage: directed vector table, corner sequences,
// and randomized samples against a queue-based reference model.
module tb_sample_filter_stage;
    localparam int LOG2_TAPS = 3;
    localparam int DW        = 14;
    localparam int TAPS      = 1 << LOG2_TAPS;
    localparam int MAXV      = (1 << (DW - 1)) - 1;
    localparam int MINV      = -(1 << (DW - 1));
    localparam int EW        = DW + 12 + 1;

`ifdef SAMPLE_FILTER_SAT_EN
    localparam int         OVF_Y   = 8191;
    localparam logic [11:0] OVF_DAC = 12'hFFF;
`else
    localparam int         OVF_Y   = -1;
    localparam logic [11:0] OVF_DAC = 12'h7FF;
`endif

    logic                 clk;
    logic                 reset;
    logic                 sample_tick;
    logic signed [DW-1:0] sample_in;
    logic [1:0]           mode;
    logic signed [DW-1:0] y_out;
    logic [11:0]          dac_code;
    logic                 out_valid;
    logic                 overflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic [EW-1:0] exp_q[$];
    int            hist_m[$];
    bit            ovf_m;

    sample_filter_stage #(.LOG2_TAPS(LOG2_TAPS), .DW(DW)) dut (
        .CLK_50M     (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .sample_in   (sample_in),
        .mode        (mode),
        .y_out       (y_out),
        .dac_code    (dac_code),
        .out_valid   (out_valid),
        .overflow    (overflow)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic void model_reset();
        hist_m.delete();
        for (int i = 0; i < TAPS; i++) hist_m.push_back(0);
        ovf_m = 1'b0;
    endfunction

    function automatic logic [EW-1:0] model_step(input int x, input logic [1:0] m);
        int prev;
        int s;
        int d;
        int r;
        int dac;
        int q;
        logic signed [DW-1:0] y_bits;
        prev = hist_m[0];
        hist_m.push_front(x);
        void'(hist_m.pop_back());
        s = 0;
        foreach (hist_m[i]) s += hist_m[i];
        r = 0;
        case (m)
            2'b00: r = prev;
            2'b01: begin
                d = x - prev;
                r = d;
                if (d > MAXV || d < MINV) begin
                    ovf_m = 1'b1;
`ifdef SAMPLE_FILTER_SAT_EN
                    r = (d > MAXV) ? MAXV : MINV;
`else
                    r = (((d - MINV) % (1 << DW)) + (1 << DW)) % (1 << DW) + MINV;
`endif
                end
            end
            2'b10: begin
                q = s / TAPS;
                if ((s % TAPS) != 0 && s < 0) q = q - 1;
                r = q;
            end
            default: r = 0;
        endcase
        dac    = (r - MINV) / (1 << (DW - 12));
        y_bits = DW'(r);
        return {ovf_m, 12'(dac), y_bits};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset(input bit check_state);
        @(negedge clk);
        reset       = 1'b1;
        sample_tick = 1'b0;
        @(negedge clk);
        if (check_state) begin
            check("rst_y",     int'(y_out),     0);
            check("rst_dac",   int'(dac_code),  32'h800);
            check("rst_valid", int'(out_valid), 0);
            check("rst_ovf",   int'(overflow),  0);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic send(input int x, input logic [1:0] m, output logic got,
                        output int y, output logic [11:0] dac, output logic ov);
        got = 1'b0;
        y   = 0;
        dac = '0;
        ov  = 1'b0;
        @(negedge clk);
        sample_in   = DW'(x);
        mode        = m;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                y   = int'(y_out);
                dac = dac_code;
                ov  = overflow;
            end
        end
        check("valid_seen", int'(got), 1);
        if (got) begin
            @(negedge clk);
            check("pulse_width", int'(out_valid), 0);
        end
    endtask

    typedef struct {
        bit          rst;
        int          x;
        logic [1:0]  m;
        int          y;
        logic [11:0] dac;
        bit          ov;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic        got;
        int          y;
        logic [11:0] dac;
        logic        ov;
        logic [EW-1:0] e;
        int          pulses;
        int          high_cycles;
        logic        prev_v;

        reset       = 1'b1;
        sample_tick = 1'b0;
        sample_in   = '0;
        mode        = 2'b00;
        model_reset();

        // relay after reset, differentiator, moving average, overflow, mode switch
        vecs.push_back('{1'b1,   100, 2'b00,    0, 12'h800, 1'b0});
        vecs.push_back('{1'b1,   100, 2'b01,  100, 12'h819, 1'b0});
        vecs.push_back('{1'b0,   300, 2'b01,  200, 12'h832, 1'b0});
        vecs.push_back('{1'b0,   250, 2'b01,  -50, 12'h7F3, 1'b0});
        vecs.push_back('{1'b1,   800, 2'b10,  100, 12'h819, 1'b0});
        vecs.push_back('{1'b0,   800, 2'b10,  200, 12'h832, 1'b0});
        vecs.push_back('{1'b0,   800, 2'b10,  300, 12'h84B, 1'b0});
        vecs.push_back('{1'b0,   800, 2'b10,  400, 12'h864, 1'b0});
        vecs.push_back('{1'b0,   800, 2'b10,  500, 12'h87D, 1'b0});
        vecs.push_back('{1'b0,   800, 2'b10,  600, 12'h896, 1'b0});
        vecs.push_back('{1'b0,   800, 2'b10,  700, 12'h8AF, 1'b0});
        vecs.push_back('{1'b0,   800, 2'b10,  800, 12'h8C8, 1'b0});
        vecs.push_back('{1'b0,     0, 2'b10,  700, 12'h8AF, 1'b0});
        vecs.push_back('{1'b1, -8192, 2'b01, -8192, 12'h000, 1'b0});
        vecs.push_back('{1'b0,  8191, 2'b01, OVF_Y, OVF_DAC, 1'b1});
        vecs.push_back('{1'b0,  1000, 2'b11,    0, 12'h800, 1'b1});
        vecs.push_back('{1'b1,   100, 2'b00,    0, 12'h800, 1'b0});
        vecs.push_back('{1'b0,   200, 2'b00,  100, 12'h819, 1'b0});
        vecs.push_back('{1'b0,   300, 2'b10,   75, 12'h812, 1'b0});

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset(1'b1);
            send(vecs[i].x, vecs[i].m, got, y, dac, ov);
            if (got) begin
                check($sformatf("vec%0d_y", i),   y,          vecs[i].y);
                check($sformatf("vec%0d_dac", i), int'(dac),  int'(vecs[i].dac));
                check($sformatf("vec%0d_ovf", i), int'(ov),   int'(vecs[i].ov));
            end
        end

        // reset while an output is pending cancels it; next accept starts from zero history
        do_reset(1'b0);
        void'(model_step(500, 2'b00));
        @(negedge clk);
        sample_in   = DW'(500);
        mode        = 2'b00;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        reset       = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("rst_cancel_pulses", pulses, 0);
        send(800, 2'b10, got, y, dac, ov);
        if (got) check("rst_cancel_avg", y, 100);

        // tick held high: one accept per rising edge only
        do_reset(1'b0);
        pulses      = 0;
        high_cycles = 0;
        prev_v      = 1'b0;
        @(negedge clk);
        sample_in   = DW'(123);
        mode        = 2'b00;
        sample_tick = 1'b1;
        for (int i = 0; i < 44; i++) begin
            @(negedge clk);
            if (i == 19) sample_tick = 1'b0;
            if (i == 20) sample_tick = 1'b1;
            if (i == 40) sample_tick = 1'b0;
            if (out_valid) high_cycles++;
            if (out_valid && !prev_v) pulses++;
            prev_v = out_valid;
        end
        check("held_pulses", pulses, 2);
        check("held_high_cycles", high_cycles, 2);

        // randomized run against the reference model
        do_reset(1'b0);
        for (int n = 0; n < 250; n++) begin
            int          x;
            logic [1:0]  m;
            if ($urandom_range(0, 3) == 0) x = int'($urandom_range(0, 16383)) - 8192;
            else                           x = int'($urandom_range(0, 2000)) - 1000;
            m = 2'($urandom_range(0, 3));
            exp_q.push_back(model_step(x, m));
            send(x, m, got, y, dac, ov);
            e = exp_q.pop_front();
            if (got) begin
                check("rnd_y",   y,         int'($signed(e[DW-1:0])));
                check("rnd_dac", int'(dac), int'(e[DW+11:DW]));
                check("rnd_ovf", int'(ov),  int'(e[EW-1]));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
